// File: rtl/piso_serializer.sv
// Parallel-in, serial-out transmitter: one-word holding buffer in front of an
// MSB-first shift register. Successive words leave back-to-back with no gap.
module piso_serializer #(
  parameter int WIDTH = 4
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             ShiftEn,
  input  logic             LoadValid,
  input  logic [WIDTH-1:0] ParallelIn,
  output logic             LoadReady,
  output logic             ShiftOut,
  output logic             Busy,
  output logic             FirstBit,
  output logic             Done,
  output logic             DbgState
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shiftReg;
  logic [CW-1:0]    bitCnt;
  logic [WIDTH-1:0] holdData;
  logic             holdFull;

  // Load handshake: a word moves from ParallelIn into the holding buffer on
  // any edge where LoadValid && LoadReady. LoadReady is a pure register
  // decode (!holdFull), so it never depends combinationally on LoadValid;
  // while the buffer is full the source keeps its word and LoadValid is
  // ignored. Draining and accepting never share an edge.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state    <= IDLE;
      shiftReg <= '0;
      bitCnt   <= '0;
      holdData <= '0;
      holdFull <= 1'b0;
      Done     <= 1'b0;
    end else begin
      Done <= 1'b0;

      if (LoadValid && !holdFull) begin
        holdData <= ParallelIn;
        holdFull <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (holdFull) begin
            shiftReg <= holdData;
            bitCnt   <= LastCnt;
            holdFull <= 1'b0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (ShiftEn) begin
            if (bitCnt != '0) begin
              shiftReg <= {shiftReg[WIDTH-2:0], 1'b0};
              bitCnt   <= bitCnt - CW'(1);
            end else begin
              Done <= 1'b1;
              // Last bit consumed: chain straight into a waiting word.
              if (holdFull) begin
                shiftReg <= holdData;
                bitCnt   <= LastCnt;
                holdFull <= 1'b0;
              end else begin
                shiftReg <= '0;
                state    <= IDLE;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign LoadReady = !holdFull;
  assign ShiftOut  = shiftReg[WIDTH-1];
  assign Busy      = (state == SHIFT);
  assign FirstBit  = (state == SHIFT) && (bitCnt == LastCnt);
  assign DbgState  = state;

endmodule

// File: tb/tb_piso_serializer.sv
// Directed bench for piso_serializer (WIDTH = 4): table of single frames plus
// hand-written back-to-back, gated-rate, loopback and mid-frame-reset sequences.
module tb_piso_serializer;

  logic       Clk;
  logic       Rst_n;
  logic       ShiftEn;
  logic       LoadValid;
  logic [3:0] ParallelIn;
  logic       LoadReady;
  logic       ShiftOut;
  logic       Busy;
  logic       FirstBit;
  logic       Done;
  logic       DbgState;

  int nCompared = 0;
  int nMismatched = 0;

  logic [3:0] rxReg;

  typedef struct {
    logic [3:0] word;
    logic [3:0] expBits;
  } vec_t;

  vec_t vecs[6];

  piso_serializer #(.WIDTH(4)) dut (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .ShiftEn    (ShiftEn),
    .LoadValid  (LoadValid),
    .ParallelIn (ParallelIn),
    .LoadReady  (LoadReady),
    .ShiftOut   (ShiftOut),
    .Busy       (Busy),
    .FirstBit   (FirstBit),
    .Done       (Done),
    .DbgState   (DbgState)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  // Model of the receiving 4-bit SIPO: it samples on ShiftEn && Busy edges.
  always @(posedge Clk) begin
    if (Rst_n && ShiftEn && Busy) rxReg <= {rxReg[2:0], ShiftOut};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".LoadReady"}, LoadReady, 1);
    check({tag, ".ShiftOut"},  ShiftOut,  0);
    check({tag, ".Busy"},      Busy,      0);
    check({tag, ".FirstBit"},  FirstBit,  0);
    check({tag, ".Done"},      Done,      0);
    check({tag, ".DbgState"},  DbgState,  0);
  endtask

  // One isolated frame with ShiftEn held high.
  task automatic run_frame(input logic [3:0] word, input logic [3:0] expBits, input string tag);
    ShiftEn    = 1'b1;
    LoadValid  = 1'b1;
    ParallelIn = word;
    tick();
    check({tag, ".accept_ready"}, LoadReady, 0);
    check({tag, ".accept_busy"},  Busy,      0);
    LoadValid = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s.bit%0d", tag, i),   ShiftOut, expBits[3-i]);
      check($sformatf("%s.busy%0d", tag, i),  Busy,     1);
      check($sformatf("%s.first%0d", tag, i), FirstBit, (i == 0) ? 1 : 0);
      check($sformatf("%s.done%0d", tag, i),  Done,     0);
      tick();
    end
    check({tag, ".done_pulse"}, Done, 1);
    check({tag, ".done_busy"},  Busy, 0);
    tick();
    check({tag, ".done_clear"}, Done, 0);
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (Done) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] expB;
    logic [7:0] expF;
    logic [7:0] expD;
    logic [7:0] expR;
    logic [3:0] expG;
    bit         ok;

    vecs[0] = '{word: 4'b1011, expBits: 4'b1011};
    vecs[1] = '{word: 4'b0000, expBits: 4'b0000};
    vecs[2] = '{word: 4'b1111, expBits: 4'b1111};
    vecs[3] = '{word: 4'b1000, expBits: 4'b1000};
    vecs[4] = '{word: 4'b0001, expBits: 4'b0001};
    vecs[5] = '{word: 4'b0110, expBits: 4'b0110};

    // Reset held with random inputs.
    Rst_n      = 1'b0;
    ShiftEn    = 1'b0;
    LoadValid  = 1'b0;
    ParallelIn = 4'h0;
    for (int i = 0; i < 4; i++) begin
      ShiftEn    = 1'($urandom_range(0, 1));
      LoadValid  = 1'($urandom_range(0, 1));
      ParallelIn = 4'($urandom_range(0, 15));
      tick();
      check_idle($sformatf("reset%0d", i));
    end
    ShiftEn   = 1'b0;
    LoadValid = 1'b0;
    Rst_n     = 1'b1;
    tick();
    check_idle("post_reset");

    // Table of single frames.
    for (int v = 0; v < 6; v++) begin
      run_frame(vecs[v].word, vecs[v].expBits, $sformatf("vec%0d", v));
    end

    // Back-to-back: 4'hA then 4'h5 with no gap on the line.
    expB = 8'b1010_0101;
    expF = 8'b1000_1000;
    expD = 8'b0000_1000;
    expR = 8'b1000_1111;
    ShiftEn    = 1'b1;
    LoadValid  = 1'b1;
    ParallelIn = 4'hA;
    tick();
    check("b2b.accept_ready", LoadReady, 0);
    ParallelIn = 4'h5;
    tick();
    for (int i = 0; i < 8; i++) begin
      if (i == 1) LoadValid = 1'b0;
      check($sformatf("b2b.bit%0d", i),   ShiftOut,  expB[7-i]);
      check($sformatf("b2b.busy%0d", i),  Busy,      1);
      check($sformatf("b2b.first%0d", i), FirstBit,  expF[7-i]);
      check($sformatf("b2b.done%0d", i),  Done,      expD[7-i]);
      check($sformatf("b2b.ready%0d", i), LoadReady, expR[7-i]);
      tick();
    end
    check("b2b.done_pulse", Done, 1);
    check("b2b.done_busy",  Busy, 0);
    tick();
    check("b2b.done_clear", Done, 0);

    // Gated rate: ShiftEn high one edge in three.
    expG       = 4'b0110;
    ShiftEn    = 1'b0;
    LoadValid  = 1'b1;
    ParallelIn = 4'b0110;
    tick();
    LoadValid = 1'b0;
    tick();
    for (int i = 0; i < 12; i++) begin
      check($sformatf("gate.bit%0d", i),   ShiftOut, expG[3 - i/3]);
      check($sformatf("gate.busy%0d", i),  Busy,     1);
      check($sformatf("gate.first%0d", i), FirstBit, (i < 3) ? 1 : 0);
      check($sformatf("gate.done%0d", i),  Done,     0);
      ShiftEn = (i % 3 == 2);
      tick();
    end
    check("gate.done_pulse", Done, 1);
    check("gate.done_busy",  Busy, 0);
    ShiftEn = 1'b0;
    tick();
    check("gate.done_clear", Done, 0);

    // Loopback into the receiver model for every 4-bit value.
    ShiftEn = 1'b1;
    for (int v = 0; v < 16; v++) begin
      LoadValid  = 1'b1;
      ParallelIn = 4'(v);
      tick();
      LoadValid = 1'b0;
      wait_done(12, ok);
      check($sformatf("loop%0d.done_seen", v), ok, 1);
      if (ok) begin
        check($sformatf("loop%0d.rx", v),   rxReg, v);
        check($sformatf("loop%0d.busy", v), Busy,  0);
      end
      tick();
    end

    // Abort: reset after two bits of 4'h9 with 4'hF waiting in the buffer.
    ShiftEn    = 1'b1;
    LoadValid  = 1'b1;
    ParallelIn = 4'h9;
    tick();
    LoadValid = 1'b0;
    tick();
    check("abort.bit0", ShiftOut, 1);
    check("abort.busy", Busy,     1);
    LoadValid  = 1'b1;
    ParallelIn = 4'hF;
    tick();
    check("abort.bit1",    ShiftOut,  0);
    check("abort.pending", LoadReady, 0);
    LoadValid = 1'b0;
    tick();
    check("abort.bit2", ShiftOut, 0);
    #3;
    Rst_n = 1'b0;
    #1;
    check_idle("abort_async");
    for (int i = 0; i < 3; i++) begin
      tick();
      check_idle($sformatf("abort_hold%0d", i));
    end
    Rst_n = 1'b1;
    tick();
    check_idle("abort_no_pending");
    run_frame(4'h3, 4'b0011, "abort_next");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in, serial-out transmitter. It is the sending end of the serial link whose receiving end is the 4-bit serial-in/parallel-out shift register.
- Accepts a WIDTH-bit word through a valid/ready load handshake and buffers one word.
- Shifts the word out MSB-first, one bit per ShiftEn strobe.
- Frames flagged by Busy/FirstBit/Done; back-to-back words go out with no gap.

Parameters:
- WIDTH, 4, word length in bits; legal range >= 2. Bit counter width is $clog2(WIDTH).

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Rst_n  input  1  asynchronous active-low reset.
- ShiftEn  input  1  bit-rate strobe; one bit consumed per cycle it is high in SHIFT.
- LoadValid  input  1  ParallelIn holds a word to send.
- ParallelIn  input  WIDTH  word to serialize; bit WIDTH-1 is sent first.
- LoadReady  output  1  holding buffer empty; word accepted on an edge where LoadValid && LoadReady.
- ShiftOut  output  1  serial data; equals shift_reg[WIDTH-1].
- Busy  output  1  a frame is on the line (state SHIFT).
- FirstBit  output  1  Busy && bit counter == WIDTH-1.
- Done  output  1  registered one-cycle pulse after a frame's last bit is consumed.

Behaviour:
- One clock. Reset is asynchronous and active-low (Rst_n); reset is asserted immediately and deasserted synchronously to Clk by the integration.
- Reset values:
  - state IDLE; shift_reg = 0; counter = 0; hold buffer empty; Done = 0.
  - Outputs therefore: ShiftOut = 0, Busy = 0, FirstBit = 0, LoadReady = 1.
- Holding buffer (one word plus a full flag):
  - LoadReady = !hold_full, driven from the register only; no combinational path from LoadValid.
  - Accept edge: hold_data <= ParallelIn, hold_full <= 1.
  - While full, LoadValid is ignored and the word stays pending at the source.
  - Same edge the buffer drains: LoadReady was 0, so no accept occurs. The next word is accepted no earlier than the following edge.
- FSM state IDLE:
  - ShiftEn is ignored.
  - Edge with hold_full = 1: shift_reg <= hold_data, counter <= WIDTH-1, hold_full <= 0, go to SHIFT.
  - Latency: word accepted at edge k -> Busy = 1 and ShiftOut = MSB after edge k+1.
- FSM state SHIFT:
  - ShiftEn = 0: shift_reg and counter hold; ShiftOut stays stable.
  - ShiftEn = 1 and counter != 0: shift_reg <= {shift_reg[WIDTH-2:0], 1'b0}, counter <= counter-1.
  - ShiftEn = 1 and counter == 0: frame ends and Done <= 1 for exactly one cycle. Then:
    - if hold_full: reload shift_reg from hold_data, counter <= WIDTH-1, hold_full <= 0, stay in SHIFT. Gapless; Busy stays 1; FirstBit = 1 the next cycle.
    - else: shift_reg <= 0, go to IDLE.
- Done is cleared on every cycle in which it is not being set.
- Each bit is on ShiftOut for exactly the interval between consecutive ShiftEn-high edges. A receiver sampling on ShiftEn && Busy edges captures the full word by the cycle in which Done = 1.
- Reset mid-frame:
  - Immediate abort; all state returns to reset values.
  - Pending hold word is discarded and Done is not pulsed.
  - The next accepted word starts a fresh frame at its MSB.
- No X propagation: ParallelIn is sampled only on accept edges.

Test Plan:
- Reset: hold Rst_n = 0 with random inputs -> ShiftOut = 0, Busy = 0, FirstBit = 0, Done = 0, LoadReady = 1. Assert Rst_n asynchronously between edges -> outputs change before the next Clk edge.
- Single frame: WIDTH = 4, ShiftEn = 1 constantly, load 4'b1011 at edge k:
  - Busy rises after edge k+1 with FirstBit = 1.
  - ShiftOut = 1, 0, 1, 1 on the four following cycles.
  - Done = 1 for one cycle after the 4th bit's edge; Busy = 0 in that same cycle.
- Back-to-back: load 4'hA, then 4'h5 while the first frame is shifting:
  - LoadReady = 0 until 4'h5 drains.
  - ShiftOut = 1010 0101 contiguous with Busy never dropping; Done pulses twice; FirstBit high on bits 1 and 5.
- Gated rate: ShiftEn high one cycle in three, load 4'b0110 -> each bit held 3 cycles, total frame 12 cycles; FirstBit spans the first 3.
- Loopback: ShiftOut -> receiver ShiftIn, receiver ShiftEn = ShiftEn && Busy, load 4'hC -> receiver ParallelOut = 4'hC in the Done cycle. Repeat for all 16 values.
- Abort: load 4'h9, assert Rst_n = 0 after 2 bits with a word pending in hold:
  - All outputs return to reset values, no Done pulse.
  - Next load of 4'h3 sends 0011 cleanly.
